// File: rtl/axi_rw_arbiter.sv
// Two-way arbiter sharing the axi_rw simple port between instruction fetch (IF) and load/store (MEM).
// Optional build macro ARB_ROUND_ROBIN_EN selects round-robin tie-breaking; fixed MEM priority otherwise.
module axi_rw_arbiter #(
    parameter int ADDR_W = 64,
    parameter int DATA_W = 64
) (
    input  logic              clock,
    input  logic              reset,

    input  logic              if_valid_i,
    output logic              if_ready_o,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic [1:0]        if_size_i,
    output logic [DATA_W-1:0] if_data_o,
    output logic [1:0]        if_resp_o,

    input  logic              mem_valid_i,
    output logic              mem_ready_o,
    input  logic              mem_req_i,
    input  logic [ADDR_W-1:0] mem_addr_i,
    input  logic [1:0]        mem_size_i,
    input  logic [DATA_W-1:0] mem_wdata_i,
    output logic [DATA_W-1:0] mem_data_o,
    output logic [1:0]        mem_resp_o,

    output logic              rw_valid_o,
    input  logic              rw_ready_i,
    output logic              rw_req_o,
    output logic [ADDR_W-1:0] rw_addr_o,
    output logic [1:0]        rw_size_o,
    output logic [DATA_W-1:0] rw_wdata_o,
    input  logic [DATA_W-1:0] rw_rdata_i,
    input  logic [1:0]        rw_resp_i
);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_DONE = 2'd2;

    localparam logic OWN_MEM = 1'b0;
    localparam logic OWN_IF  = 1'b1;

    logic [1:0] state;
    logic       owner;
    logic       last_grant;
    logic       grant_if;
    logic       xfer_done;

    // NOTE: every signal assigned in always_comb gets a value on every path, so no latch is inferred.
    always_comb begin
        grant_if = 1'b0;
`ifdef ARB_ROUND_ROBIN_EN
        if (if_valid_i && mem_valid_i)
            grant_if = (last_grant == OWN_MEM);
        else
            grant_if = if_valid_i;
`else
        grant_if = if_valid_i && !mem_valid_i;
`endif
    end

    // NOTE: sequential state uses non-blocking assignments so all registers update from pre-edge values.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state      <= ST_IDLE;
            owner      <= OWN_MEM;
            last_grant <= OWN_MEM;
            rw_req_o   <= 1'b0;
            rw_addr_o  <= '0;
            rw_size_o  <= 2'd0;
            rw_wdata_o <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (if_valid_i || mem_valid_i) begin
                        state      <= ST_BUSY;
                        owner      <= grant_if ? OWN_IF : OWN_MEM;
                        last_grant <= grant_if ? OWN_IF : OWN_MEM;
                        if (grant_if) begin
                            rw_req_o   <= 1'b0;
                            rw_addr_o  <= if_addr_i;
                            rw_size_o  <= if_size_i;
                            rw_wdata_o <= '0;
                        end else begin
                            rw_req_o   <= mem_req_i;
                            rw_addr_o  <= mem_addr_i;
                            rw_size_o  <= mem_size_i;
                            rw_wdata_o <= mem_wdata_i;
                        end
                    end
                end
                ST_BUSY: begin
                    if (rw_ready_i)
                        state <= ST_DONE;
                end
                // One dead cycle lets the finished requester drop its valid before re-arbitration.
                ST_DONE: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Any response code, including error responses, completes the transfer.
    assign rw_valid_o  = (state == ST_BUSY);
    assign xfer_done   = rw_valid_o && rw_ready_i;

    assign if_ready_o  = xfer_done && (owner == OWN_IF);
    assign mem_ready_o = xfer_done && (owner == OWN_MEM);

    assign if_data_o   = if_ready_o  ? rw_rdata_i : '0;
    assign if_resp_o   = if_ready_o  ? rw_resp_i  : 2'd0;
    assign mem_data_o  = mem_ready_o ? rw_rdata_i : '0;
    assign mem_resp_o  = mem_ready_o ? rw_resp_i  : 2'd0;

endmodule

// File: tb/tb_axi_rw_arbiter.sv
// Directed self-checking bench for axi_rw_arbiter; tie expectations follow ARB_ROUND_ROBIN_EN.
module tb_axi_rw_arbiter;

    localparam int ADDR_W = 64;
    localparam int DATA_W = 64;

    logic              clock = 1'b0;
    logic              reset;
    logic              if_valid_i;
    logic              if_ready_o;
    logic [ADDR_W-1:0] if_addr_i;
    logic [1:0]        if_size_i;
    logic [DATA_W-1:0] if_data_o;
    logic [1:0]        if_resp_o;
    logic              mem_valid_i;
    logic              mem_ready_o;
    logic              mem_req_i;
    logic [ADDR_W-1:0] mem_addr_i;
    logic [1:0]        mem_size_i;
    logic [DATA_W-1:0] mem_wdata_i;
    logic [DATA_W-1:0] mem_data_o;
    logic [1:0]        mem_resp_o;
    logic              rw_valid_o;
    logic              rw_ready_i;
    logic              rw_req_o;
    logic [ADDR_W-1:0] rw_addr_o;
    logic [1:0]        rw_size_o;
    logic [DATA_W-1:0] rw_wdata_o;
    logic [DATA_W-1:0] rw_rdata_i;
    logic [1:0]        rw_resp_i;

    int vectors = 0;
    int miscompares = 0;

    axi_rw_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
        .clock       (clock),
        .reset       (reset),
        .if_valid_i  (if_valid_i),
        .if_ready_o  (if_ready_o),
        .if_addr_i   (if_addr_i),
        .if_size_i   (if_size_i),
        .if_data_o   (if_data_o),
        .if_resp_o   (if_resp_o),
        .mem_valid_i (mem_valid_i),
        .mem_ready_o (mem_ready_o),
        .mem_req_i   (mem_req_i),
        .mem_addr_i  (mem_addr_i),
        .mem_size_i  (mem_size_i),
        .mem_wdata_i (mem_wdata_i),
        .mem_data_o  (mem_data_o),
        .mem_resp_o  (mem_resp_o),
        .rw_valid_o  (rw_valid_o),
        .rw_ready_i  (rw_ready_i),
        .rw_req_o    (rw_req_o),
        .rw_addr_o   (rw_addr_o),
        .rw_size_o   (rw_size_o),
        .rw_wdata_o  (rw_wdata_o),
        .rw_rdata_i  (rw_rdata_i),
        .rw_resp_i   (rw_resp_i)
    );

    always #5 clock = ~clock;

    task automatic check(input string tag, input logic [63:0] observed, input logic [63:0] expected);
        vectors++;
        assert (observed === expected)
        else begin
            miscompares++;
            $error("FAIL %s observed=%h expected=%h", tag, observed, expected);
        end
    endtask

    // Advance to just after the next rising edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    localparam logic [63:0] IF_ADDR_T4  = 64'h8000_0100;
    localparam logic [63:0] MEM_ADDR_T4 = 64'h8000_2000;

    initial begin
        logic [3:0] exp_if_order;
        int         waited;

`ifdef ARB_ROUND_ROBIN_EN
        exp_if_order = 4'b0101;   // bit i = 1 means transfer i goes to IF: IF, MEM, IF, MEM
`else
        exp_if_order = 4'b0000;   // MEM wins every tie
`endif

        reset       = 1'b1;
        if_valid_i  = 1'b0;
        if_addr_i   = '0;
        if_size_i   = 2'd0;
        mem_valid_i = 1'b0;
        mem_req_i   = 1'b0;
        mem_addr_i  = '0;
        mem_size_i  = 2'd0;
        mem_wdata_i = '0;
        rw_ready_i  = 1'b0;
        rw_rdata_i  = '0;
        rw_resp_i   = 2'd0;

        #12;
        check("rst_rw_valid",  64'(rw_valid_o),  64'd0);
        check("rst_rw_addr",   rw_addr_o,        64'd0);
        check("rst_rw_wdata",  rw_wdata_o,       64'd0);
        check("rst_if_ready",  64'(if_ready_o),  64'd0);
        check("rst_mem_ready", 64'(mem_ready_o), 64'd0);
        step();
        reset = 1'b0;

        // 1: IF-only read, slave answers in the third BUSY cycle
        step();
        if_valid_i = 1'b1;
        if_addr_i  = 64'h8000_0000;
        if_size_i  = 2'd3;
        #1;
        check("t1_valid_cycle_n", 64'(rw_valid_o), 64'd0);
        step();
        check("t1_valid_n1", 64'(rw_valid_o), 64'd1);
        check("t1_addr",     rw_addr_o,       64'h8000_0000);
        check("t1_size",     64'(rw_size_o),  64'd3);
        check("t1_req",      64'(rw_req_o),   64'd0);
        check("t1_wdata",    rw_wdata_o,      64'd0);
        step();
        check("t1_no_early_ready", 64'(if_ready_o), 64'd0);
        step();
        rw_ready_i = 1'b1;
        rw_rdata_i = 64'h1234;
        rw_resp_i  = 2'd0;
        #1;
        check("t1_if_ready",  64'(if_ready_o),  64'd1);
        check("t1_if_data",   if_data_o,        64'h1234);
        check("t1_if_resp",   64'(if_resp_o),   64'd0);
        check("t1_mem_ready", 64'(mem_ready_o), 64'd0);
        check("t1_mem_data",  mem_data_o,       64'd0);
        step();
        rw_ready_i = 1'b0;
        rw_rdata_i = '0;
        if_valid_i = 1'b0;
        #1;
        check("t1_done_valid", 64'(rw_valid_o), 64'd0);
        check("t1_done_ready", 64'(if_ready_o), 64'd0);
        check("t1_done_data",  if_data_o,       64'd0);
        step();
        check("t1_idle_valid", 64'(rw_valid_o), 64'd0);
        step();
        check("t1_idle2_valid", 64'(rw_valid_o), 64'd0);

        // 2: MEM write; write data must stay frozen while BUSY
        mem_valid_i = 1'b1;
        mem_req_i   = 1'b1;
        mem_addr_i  = 64'h8000_1000;
        mem_wdata_i = 64'hDEAD_BEEF;
        mem_size_i  = 2'd2;
        step();
        check("t2_valid", 64'(rw_valid_o), 64'd1);
        check("t2_req",   64'(rw_req_o),   64'd1);
        check("t2_size",  64'(rw_size_o),  64'd2);
        check("t2_wdata", rw_wdata_o,      64'hDEAD_BEEF);
        mem_wdata_i = 64'h0;
        mem_addr_i  = 64'h0;
        step();
        check("t2_wdata_frozen", rw_wdata_o, 64'hDEAD_BEEF);
        check("t2_addr_frozen",  rw_addr_o,  64'h8000_1000);
        rw_ready_i = 1'b1;
        #1;
        check("t2_mem_ready", 64'(mem_ready_o), 64'd1);
        check("t2_if_ready",  64'(if_ready_o),  64'd0);
        step();
        rw_ready_i  = 1'b0;
        mem_valid_i = 1'b0;
        mem_req_i   = 1'b0;
        #1;
        check("t2_single_pulse", 64'(mem_ready_o), 64'd0);
        check("t2_valid_fall",   64'(rw_valid_o),  64'd0);
        step();

        // 5: error response on an IF read still completes
        if_valid_i = 1'b1;
        if_addr_i  = 64'h8000_0008;
        if_size_i  = 2'd2;
        step();
        check("t5_valid", 64'(rw_valid_o), 64'd1);
        rw_ready_i = 1'b1;
        rw_resp_i  = 2'b10;
        rw_rdata_i = 64'h55;
        #1;
        check("t5_if_resp",  64'(if_resp_o),  64'd2);
        check("t5_if_ready", 64'(if_ready_o), 64'd1);
        check("t5_mem_resp", 64'(mem_resp_o), 64'd0);
        step();
        rw_ready_i = 1'b0;
        rw_resp_i  = 2'd0;
        rw_rdata_i = '0;
        if_valid_i = 1'b0;
        #1;
        check("t5_done_valid", 64'(rw_valid_o), 64'd0);
        check("t5_resp_clear", 64'(if_resp_o),  64'd0);
        step();
        check("t5_idle_valid", 64'(rw_valid_o), 64'd0);

        // 3: simultaneous requests; MEM first (priority, or round-robin after IF), IF after turnaround
        if_valid_i  = 1'b1;
        if_addr_i   = 64'h8000_0040;
        if_size_i   = 2'd3;
        mem_valid_i = 1'b1;
        mem_req_i   = 1'b0;
        mem_addr_i  = 64'h8000_3000;
        mem_size_i  = 2'd3;
        step();
        check("t3_first_addr", rw_addr_o,       64'h8000_3000);
        check("t3_first_req",  64'(rw_req_o),   64'd0);
        step();
        rw_ready_i = 1'b1;
        rw_rdata_i = 64'h77;
        #1;
        check("t3_mem_ready", 64'(mem_ready_o), 64'd1);
        check("t3_mem_data",  mem_data_o,       64'h77);
        check("t3_if_ready",  64'(if_ready_o),  64'd0);
        check("t3_if_data",   if_data_o,        64'd0);
        step();
        rw_ready_i  = 1'b0;
        rw_rdata_i  = '0;
        mem_valid_i = 1'b0;
        #1;
        check("t3_gap1_valid", 64'(rw_valid_o), 64'd0);
        step();
        check("t3_gap2_valid", 64'(rw_valid_o), 64'd0);
        step();
        check("t3_if_valid_rise", 64'(rw_valid_o), 64'd1);
        check("t3_if_addr",       rw_addr_o,       64'h8000_0040);
        rw_ready_i = 1'b1;
        rw_rdata_i = 64'h88;
        #1;
        check("t3_if_ready2", 64'(if_ready_o), 64'd1);
        check("t3_if_data2",  if_data_o,       64'h88);
        step();
        rw_ready_i = 1'b0;
        rw_rdata_i = '0;
        if_valid_i = 1'b0;
        step();

        // 6: reset asserted while BUSY
        mem_valid_i = 1'b1;
        mem_req_i   = 1'b1;
        mem_addr_i  = 64'h8000_4000;
        mem_wdata_i = 64'hCAFE;
        mem_size_i  = 2'd1;
        step();
        check("t6_busy_valid", 64'(rw_valid_o), 64'd1);
        reset = 1'b1;
        #1;
        check("t6_valid_drop", 64'(rw_valid_o), 64'd0);
        check("t6_addr_clear", rw_addr_o,       64'd0);
        check("t6_wdata_clr",  rw_wdata_o,      64'd0);
        check("t6_req_clear",  64'(rw_req_o),   64'd0);
        check("t6_size_clear", 64'(rw_size_o),  64'd0);
        mem_valid_i = 1'b0;
        mem_req_i   = 1'b0;
        mem_wdata_i = '0;
        step();
        reset = 1'b0;
        step();
        check("t6_idle_valid", 64'(rw_valid_o), 64'd0);

        // 4: both requesters held valid for four transfers, starting from reset arbitration state
        if_valid_i  = 1'b1;
        if_addr_i   = IF_ADDR_T4;
        if_size_i   = 2'd3;
        mem_valid_i = 1'b1;
        mem_req_i   = 1'b0;
        mem_addr_i  = MEM_ADDR_T4;
        mem_size_i  = 2'd3;
        for (int t = 0; t < 4; t++) begin
            waited = 0;
            while (!rw_valid_o && waited < 6) begin
                step();
                waited++;
            end
            check($sformatf("t4_valid_%0d", t), 64'(rw_valid_o), 64'd1);
            check($sformatf("t4_addr_%0d", t), rw_addr_o,
                  exp_if_order[t] ? IF_ADDR_T4 : MEM_ADDR_T4);
            rw_ready_i = 1'b1;
            #1;
            check($sformatf("t4_if_ready_%0d", t),  64'(if_ready_o),  64'(exp_if_order[t]));
            check($sformatf("t4_mem_ready_%0d", t), 64'(mem_ready_o), 64'(!exp_if_order[t]));
            step();
            rw_ready_i = 1'b0;
        end
        if_valid_i  = 1'b0;
        mem_valid_i = 1'b0;
        step();
        step();

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
